// File: rtl/zybo_dvi_pkg.sv
// Shared definitions for the Zybo DVI transmit path.
// Holds the default 640x480@60 timing constants, the line/frame totals,
// the 24-bit pixel type, the output payload struct and the colour-bar table.
// Optional feature: COLOR_BAR_EN (consumers select bars vs flat fill).
package zybo_dvi_pkg;

    localparam int unsigned CNT_W   = 10;
    localparam int unsigned FRAME_W = 8;
    localparam int unsigned LED_W   = 4;
    localparam int unsigned PIX_W   = 24;

    localparam int unsigned DEF_H_VISIBLE = 640;
    localparam int unsigned DEF_H_FRONT   = 16;
    localparam int unsigned DEF_H_SYNC    = 96;
    localparam int unsigned DEF_H_BACK    = 48;
    localparam int unsigned DEF_V_VISIBLE = 480;
    localparam int unsigned DEF_V_FRONT   = 10;
    localparam int unsigned DEF_V_SYNC    = 2;
    localparam int unsigned DEF_V_BACK    = 33;

    localparam int unsigned H_TOTAL = DEF_H_VISIBLE + DEF_H_FRONT + DEF_H_SYNC + DEF_H_BACK;
    localparam int unsigned V_TOTAL = DEF_V_VISIBLE + DEF_V_FRONT + DEF_V_SYNC + DEF_V_BACK;

    typedef logic [PIX_W-1:0] pixel_t;

    // Registered video payload handed to the TMDS serializer.
    typedef struct packed {
        logic   hsync_n;
        logic   vsync_n;
        logic   de;
        pixel_t data;
    } vout_t;

    localparam pixel_t FLAT_GREY = 24'h808080;
    localparam pixel_t BLANK     = 24'h000000;

    // Bar colours left to right: white, yellow, cyan, green, magenta, red, blue, black.
    localparam pixel_t BAR_COLORS [8] = '{
        24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
        24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000
    };

    function automatic pixel_t bar_color(input logic [2:0] idx);
        return BAR_COLORS[idx];
    endfunction

endpackage

// File: rtl/zybo_dvi_vsync_generator.sv
// Video timing generator: horizontal/vertical counters plus sync/de flags.
// Ports:
//   clk_i, rst_ni     pixel clock, async active-low reset
//   h_count_o         current pixel within the line (registered)
//   v_count_o         current line within the frame (registered)
//   h_wrap_c_o        h counter is on its last pixel (combinational)
//   v_wrap_c_o        v counter is on its last line (combinational)
//   hsync_n_c_o       active-low hsync for the current counter state
//   vsync_n_c_o       active-low vsync for the current counter state
//   de_c_o            visible-area flag for the current counter state
module vsync_generator
    import zybo_dvi_pkg::*;
#(
    parameter int unsigned H_VISIBLE = DEF_H_VISIBLE,
    parameter int unsigned H_FRONT   = DEF_H_FRONT,
    parameter int unsigned H_SYNC    = DEF_H_SYNC,
    parameter int unsigned H_BACK    = DEF_H_BACK,
    parameter int unsigned V_VISIBLE = DEF_V_VISIBLE,
    parameter int unsigned V_FRONT   = DEF_V_FRONT,
    parameter int unsigned V_SYNC    = DEF_V_SYNC,
    parameter int unsigned V_BACK    = DEF_V_BACK
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    output logic [CNT_W-1:0] h_count_o,
    output logic [CNT_W-1:0] v_count_o,
    output logic             h_wrap_c_o,
    output logic             v_wrap_c_o,
    output logic             hsync_n_c_o,
    output logic             vsync_n_c_o,
    output logic             de_c_o
);

    localparam int unsigned H_LEN  = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_LEN  = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int unsigned HS_BEG = H_VISIBLE + H_FRONT;
    localparam int unsigned HS_END = H_VISIBLE + H_FRONT + H_SYNC;
    localparam int unsigned VS_BEG = V_VISIBLE + V_FRONT;
    localparam int unsigned VS_END = V_VISIBLE + V_FRONT + V_SYNC;

    logic [CNT_W-1:0] h_q, h_d;
    logic [CNT_W-1:0] v_q, v_d;
    logic             h_wrap_c, v_wrap_c;

    // Next-state counters; v only advances on the last pixel of a line.
    always_comb begin
        h_wrap_c = (h_q == CNT_W'(H_LEN - 1));
        v_wrap_c = (v_q == CNT_W'(V_LEN - 1));
        h_d      = h_wrap_c ? '0 : h_q + CNT_W'(1);
        v_d      = v_q;
        if (h_wrap_c) begin
            v_d = v_wrap_c ? '0 : v_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            h_q <= '0;
            v_q <= '0;
        end else begin
            h_q <= h_d;
            v_q <= v_d;
        end
    end

    assign h_count_o   = h_q;
    assign v_count_o   = v_q;
    assign h_wrap_c_o  = h_wrap_c;
    assign v_wrap_c_o  = v_wrap_c;
    assign hsync_n_c_o = !((h_q >= CNT_W'(HS_BEG)) && (h_q < CNT_W'(HS_END)));
    assign vsync_n_c_o = !((v_q >= CNT_W'(VS_BEG)) && (v_q < CNT_W'(VS_END)));
    assign de_c_o      = (h_q < CNT_W'(H_VISIBLE)) && (v_q < CNT_W'(V_VISIBLE));

endmodule

// File: rtl/zybo_dvi_top.sv
// Zybo DVI transmit top: video timing, pixel source, frame counter and LEDs.
// Optional feature macro: COLOR_BAR_EN (8 vertical colour bars; otherwise flat grey).
// Ports:
//   clk          pixel clock (25 MHz nominal)
//   reset_n      async active-low reset
//   vout_hsync   hsync, active low (registered)
//   vout_vsync   vsync, active low (registered)
//   vout_de      data enable (registered)
//   vout_data    {R,G,B} pixel, zero outside the visible area (registered)
//   led          frame_count[7:4] (registered)
module zybo_dvi_top
    import zybo_dvi_pkg::*;
#(
    parameter int unsigned H_VISIBLE = DEF_H_VISIBLE,
    parameter int unsigned H_FRONT   = DEF_H_FRONT,
    parameter int unsigned H_SYNC    = DEF_H_SYNC,
    parameter int unsigned H_BACK    = DEF_H_BACK,
    parameter int unsigned V_VISIBLE = DEF_V_VISIBLE,
    parameter int unsigned V_FRONT   = DEF_V_FRONT,
    parameter int unsigned V_SYNC    = DEF_V_SYNC,
    parameter int unsigned V_BACK    = DEF_V_BACK
) (
    input  logic             clk,
    input  logic             reset_n,
    output logic             vout_hsync,
    output logic             vout_vsync,
    output logic             vout_de,
    output logic [PIX_W-1:0] vout_data,
    output logic [LED_W-1:0] led
);

    logic [CNT_W-1:0] h_count, v_count;
    logic             h_wrap_c, v_wrap_c;
    logic             hsync_n_c, vsync_n_c, de_c;

    vsync_generator #(
        .H_VISIBLE (H_VISIBLE),
        .H_FRONT   (H_FRONT),
        .H_SYNC    (H_SYNC),
        .H_BACK    (H_BACK),
        .V_VISIBLE (V_VISIBLE),
        .V_FRONT   (V_FRONT),
        .V_SYNC    (V_SYNC),
        .V_BACK    (V_BACK)
    ) u_timing (
        .clk_i       (clk),
        .rst_ni      (reset_n),
        .h_count_o   (h_count),
        .v_count_o   (v_count),
        .h_wrap_c_o  (h_wrap_c),
        .v_wrap_c_o  (v_wrap_c),
        .hsync_n_c_o (hsync_n_c),
        .vsync_n_c_o (vsync_n_c),
        .de_c_o      (de_c)
    );

    // Pixel source for the visible area.
    pixel_t pixel_c;
    logic   unused_cnt;
`ifdef COLOR_BAR_EN
    localparam int unsigned BAR_W = H_VISIBLE / 8;
    logic [2:0] bar_idx_c;
    assign bar_idx_c  = 3'(h_count / CNT_W'(BAR_W));
    assign pixel_c    = bar_color(bar_idx_c);
    assign unused_cnt = ^v_count;
`else
    assign pixel_c    = FLAT_GREY;
    assign unused_cnt = ^{h_count, v_count};
`endif

    vout_t              vout_d, vout_q;
    logic [FRAME_W-1:0] frame_d, frame_q;
    logic [LED_W-1:0]   led_d, led_q;

    // Output payload and frame counter next state; frame advances on the last pixel of a frame.
    always_comb begin
        vout_d.hsync_n = hsync_n_c;
        vout_d.vsync_n = vsync_n_c;
        vout_d.de      = de_c;
        vout_d.data    = de_c ? pixel_c : BLANK;
        frame_d        = frame_q;
        if (h_wrap_c && v_wrap_c) begin
            frame_d = frame_q + FRAME_W'(1);
        end
        led_d = frame_q[FRAME_W-1 -: LED_W];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vout_q  <= '{hsync_n: 1'b1, vsync_n: 1'b1, de: 1'b0, data: BLANK};
            frame_q <= '0;
            led_q   <= '0;
        end else begin
            vout_q  <= vout_d;
            frame_q <= frame_d;
            led_q   <= led_d;
        end
    end

    assign vout_hsync = vout_q.hsync_n;
    assign vout_vsync = vout_q.vsync_n;
    assign vout_de    = vout_q.de;
    assign vout_data  = vout_q.data;
    assign led        = led_q;

endmodule

// File: tb/tb_zybo_dvi_top.sv
// Bench for zybo_dvi_top. Instance dut uses the default 640x480 timing;
// instance dut_s uses a reduced timing (24x8 totals) so whole frames and the
// 256-frame LED wrap fit in a short run. Expected outputs come from a small
// timing model pushed into per-instance queues as each clock edge is driven.
module tb_zybo_dvi_top;

    localparam int unsigned DH_V = 640, DH_F = 16, DH_S = 96, DH_B = 48;
    localparam int unsigned DV_V = 480, DV_F = 10, DV_S = 2,  DV_B = 33;
    localparam int unsigned SH_V = 16,  SH_F = 2,  SH_S = 4,  SH_B = 2;
    localparam int unsigned SV_V = 4,   SV_F = 1,  SV_S = 2,  SV_B = 1;
    localparam int unsigned S_LINE  = SH_V + SH_F + SH_S + SH_B;   // 24
    localparam int unsigned S_FRAME = S_LINE * (SV_V + SV_F + SV_S + SV_B); // 192

    typedef struct packed {
        logic        hs;
        logic        vs;
        logic        de;
        logic [23:0] data;
        logic [3:0]  led;
    } vout_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic d_hs, d_vs, d_de, s_hs, s_vs, s_de;
    logic [23:0] d_data, s_data;
    logic [3:0]  d_led, s_led;

    int unsigned checks = 0;
    int unsigned failures = 0;
    int unsigned e = 0;     // clock edges since reset release
    vout_t q_d[$];
    vout_t q_s[$];

    always #5 clk = ~clk;

    zybo_dvi_top dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .vout_hsync (d_hs),
        .vout_vsync (d_vs),
        .vout_de    (d_de),
        .vout_data  (d_data),
        .led        (d_led)
    );

    zybo_dvi_top #(
        .H_VISIBLE (SH_V), .H_FRONT (SH_F), .H_SYNC (SH_S), .H_BACK (SH_B),
        .V_VISIBLE (SV_V), .V_FRONT (SV_F), .V_SYNC (SV_S), .V_BACK (SV_B)
    ) dut_s (
        .clk        (clk),
        .reset_n    (reset_n),
        .vout_hsync (s_hs),
        .vout_vsync (s_vs),
        .vout_de    (s_de),
        .vout_data  (s_data),
        .led        (s_led)
    );

    // Expected outputs after edge ed for a given timing.
    function automatic vout_t model(input int unsigned hv, hf, hsw, hb, vv, vf, vsw, vb,
                                    input int unsigned ed);
        vout_t r;
        int unsigned s, ht, vt, h, v, fc;
        logic [23:0] tbl [8];
        tbl = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
        r = '{hs: 1'b1, vs: 1'b1, de: 1'b0, data: 24'h0, led: 4'h0};
        if (ed == 0) return r;
        s  = ed - 1;
        ht = hv + hf + hsw + hb;
        vt = vv + vf + vsw + vb;
        h  = s % ht;
        v  = (s / ht) % vt;
        fc = (s / (ht * vt)) % 256;
        r.hs  = !(h >= hv + hf && h < hv + hf + hsw);
        r.vs  = !(v >= vv + vf && v < vv + vf + vsw);
        r.de  = (h < hv) && (v < vv);
`ifdef COLOR_BAR_EN
        r.data = r.de ? tbl[(h / (hv / 8)) % 8] : 24'h0;
`else
        r.data = r.de ? 24'h808080 : 24'h0;
`endif
        r.led = 4'(fc >> 4);
        return r;
    endfunction

    function automatic vout_t act_d();
        return {d_hs, d_vs, d_de, d_data, d_led};
    endfunction

    function automatic vout_t act_s();
        return {s_hs, s_vs, s_de, s_data, s_led};
    endfunction

    // Drive one clock edge, queueing what each instance should show after it.
    task automatic tick();
        q_d.push_back(model(DH_V, DH_F, DH_S, DH_B, DV_V, DV_F, DV_S, DV_B, e + 1));
        q_s.push_back(model(SH_V, SH_F, SH_S, SH_B, SV_V, SV_F, SV_S, SV_B, e + 1));
        @(posedge clk);
        #1;
        e++;
    endtask

    task automatic restart();
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
        e = 0;
        q_d.delete();
        q_s.delete();
    endtask

    task automatic test_reset();
        vout_t rst_exp;
        rst_exp = '{hs: 1'b1, vs: 1'b1, de: 1'b0, data: 24'h0, led: 4'h0};
        reset_n = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        checks++; if (d_hs !== 1'b1) begin failures++; $display("FAIL reset_hsync got=%b exp=1", d_hs); end
        checks++; if (d_vs !== 1'b1) begin failures++; $display("FAIL reset_vsync got=%b exp=1", d_vs); end
        checks++; if (d_de !== 1'b0) begin failures++; $display("FAIL reset_de got=%b exp=0", d_de); end
        checks++; if (d_data !== 24'h0) begin failures++; $display("FAIL reset_data got=%h exp=000000", d_data); end
        checks++; if (d_led !== 4'h0) begin failures++; $display("FAIL reset_led got=%h exp=0", d_led); end
        checks++; if (act_s() !== rst_exp) begin failures++; $display("FAIL reset_small got=%h exp=%h", act_s(), rst_exp); end
    endtask

    task automatic test_line_timing();
        vout_t ex, ac;
        int unsigned de_cnt = 0, hs_cnt = 0, hs_first = 0, rise1 = 0, rise2 = 0;
        logic prev_de = 1'b0;
        restart();
        for (int i = 0; i < 1601; i++) begin
            tick();
            ex = q_d.pop_front(); ac = act_d();
            checks++; if (ac !== ex) begin failures++; $display("FAIL line_sb e=%0d got=%h exp=%h", e, ac, ex); end
            ex = q_s.pop_front(); ac = act_s();
            checks++; if (ac !== ex) begin failures++; $display("FAIL line_sb_small e=%0d got=%h exp=%h", e, ac, ex); end
            if (e <= 800) begin
                if (d_de === 1'b1) de_cnt++;
                if (d_hs === 1'b0) begin
                    hs_cnt++;
                    if (hs_first == 0) hs_first = e;
                end
            end
            if (prev_de === 1'b0 && d_de === 1'b1) begin
                if (rise1 == 0) rise1 = e;
                else if (rise2 == 0) rise2 = e;
            end
            prev_de = d_de;
        end
        checks++; if (de_cnt != 640) begin failures++; $display("FAIL line_de_len got=%0d exp=640", de_cnt); end
        checks++; if (hs_cnt != 96) begin failures++; $display("FAIL line_hsync_len got=%0d exp=96", hs_cnt); end
        checks++; if (rise1 != 1) begin failures++; $display("FAIL line_first_de got=%0d exp=1", rise1); end
        checks++; if (hs_first - rise1 != 656) begin failures++; $display("FAIL line_hsync_ofs got=%0d exp=656", hs_first - rise1); end
        checks++; if (rise2 - rise1 != 800) begin failures++; $display("FAIL line_period got=%0d exp=800", rise2 - rise1); end
    endtask

    task automatic test_pixels();
        logic [23:0] pix [800];
        logic        den [800];
        int unsigned bad = 0;
        restart();
        for (int i = 0; i < 800; i++) begin
            tick();
            pix[i] = d_data;
            den[i] = d_de;
        end
        q_d.delete();
        q_s.delete();
`ifdef COLOR_BAR_EN
        checks++; if (pix[0] !== 24'hFFFFFF) begin failures++; $display("FAIL bar_px0 got=%h exp=FFFFFF", pix[0]); end
        checks++; if (pix[79] !== 24'hFFFFFF) begin failures++; $display("FAIL bar_px79 got=%h exp=FFFFFF", pix[79]); end
        checks++; if (pix[80] !== 24'hFFFF00) begin failures++; $display("FAIL bar_px80 got=%h exp=FFFF00", pix[80]); end
        checks++; if (pix[400] !== 24'hFF0000) begin failures++; $display("FAIL bar_px400 got=%h exp=FF0000", pix[400]); end
        checks++; if (pix[639] !== 24'h000000) begin failures++; $display("FAIL bar_px639 got=%h exp=000000", pix[639]); end
        for (int i = 640; i < 800; i++) if (pix[i] !== 24'h0 || den[i] !== 1'b0) bad++;
        checks++; if (bad != 0) begin failures++; $display("FAIL bar_blank bad=%0d exp=0", bad); end
`else
        for (int i = 0; i < 800; i++) begin
            if (den[i] === 1'b1 && pix[i] !== 24'h808080) bad++;
            if (den[i] !== 1'b1 && pix[i] !== 24'h000000) bad++;
        end
        checks++; if (pix[0] !== 24'h808080) begin failures++; $display("FAIL flat_px0 got=%h exp=808080", pix[0]); end
        checks++; if (pix[700] !== 24'h000000) begin failures++; $display("FAIL flat_px700 got=%h exp=000000", pix[700]); end
        checks++; if (bad != 0) begin failures++; $display("FAIL flat_line bad=%0d exp=0", bad); end
`endif
    endtask

    task automatic test_frame_timing();
        vout_t ex, ac;
        int unsigned vs_cnt = 0, fall1 = 0, fall2 = 0, de_lines = 0;
        logic prev_vs = 1'b1;
        logic line_de = 1'b0;
        restart();
        for (int i = 0; i < 320; i++) begin
            tick();
            ex = q_s.pop_front(); ac = act_s();
            checks++; if (ac !== ex) begin failures++; $display("FAIL frame_sb e=%0d got=%h exp=%h", e, ac, ex); end
            ex = q_d.pop_front(); ac = act_d();
            checks++; if (ac !== ex) begin failures++; $display("FAIL frame_sb_def e=%0d got=%h exp=%h", e, ac, ex); end
            if (e <= S_FRAME) begin
                if (s_vs === 1'b0) vs_cnt++;
                if (s_de === 1'b1) line_de = 1'b1;
                if (e % S_LINE == 0) begin
                    if (line_de) de_lines++;
                    line_de = 1'b0;
                end
            end
            if (prev_vs === 1'b1 && s_vs === 1'b0) begin
                if (fall1 == 0) fall1 = e;
                else if (fall2 == 0) fall2 = e;
            end
            prev_vs = s_vs;
        end
        checks++; if (vs_cnt != SV_S * S_LINE) begin failures++; $display("FAIL frame_vsync_len got=%0d exp=%0d", vs_cnt, SV_S * S_LINE); end
        checks++; if (fall1 != (SV_V + SV_F) * S_LINE + 1) begin failures++; $display("FAIL frame_vsync_start got=%0d exp=%0d", fall1, (SV_V + SV_F) * S_LINE + 1); end
        checks++; if (de_lines != SV_V) begin failures++; $display("FAIL frame_de_lines got=%0d exp=%0d", de_lines, SV_V); end
        checks++; if (fall2 - fall1 != S_FRAME) begin failures++; $display("FAIL frame_period got=%0d exp=%0d", fall2 - fall1, S_FRAME); end
    endtask

    task automatic test_leds();
        vout_t ex, ac;
        restart();
        for (int i = 0; i < 256 * S_FRAME + 1; i++) begin
            tick();
            ex = q_s.pop_front(); ac = act_s();
            checks++; if (ac !== ex) begin failures++; $display("FAIL led_sb e=%0d got=%h exp=%h", e, ac, ex); end
            ex = q_d.pop_front(); ac = act_d();
            checks++; if (ac !== ex) begin failures++; $display("FAIL led_sb_def e=%0d got=%h exp=%h", e, ac, ex); end
            if (e == 16 * S_FRAME) begin
                checks++; if (s_led !== 4'h0) begin failures++; $display("FAIL led_before16 got=%h exp=0", s_led); end
            end
            if (e == 16 * S_FRAME + 1) begin
                checks++; if (s_led !== 4'h1) begin failures++; $display("FAIL led_at16 got=%h exp=1", s_led); end
            end
            if (e == 256 * S_FRAME) begin
                checks++; if (s_led !== 4'hF) begin failures++; $display("FAIL led_before256 got=%h exp=F", s_led); end
            end
            if (e == 256 * S_FRAME + 1) begin
                checks++; if (s_led !== 4'h0) begin failures++; $display("FAIL led_wrap256 got=%h exp=0", s_led); end
            end
        end
    endtask

    task automatic test_reset_midline();
        vout_t ex, ac;
        restart();
        repeat (300) tick();
        q_d.delete();
        q_s.delete();
        checks++; if (d_de !== 1'b1) begin failures++; $display("FAIL mid_pre_de got=%b exp=1", d_de); end
        #1;
        reset_n = 1'b0;
        #1;
        checks++; if (d_hs !== 1'b1) begin failures++; $display("FAIL mid_hsync got=%b exp=1", d_hs); end
        checks++; if (d_vs !== 1'b1) begin failures++; $display("FAIL mid_vsync got=%b exp=1", d_vs); end
        checks++; if (d_de !== 1'b0) begin failures++; $display("FAIL mid_de got=%b exp=0", d_de); end
        checks++; if (d_data !== 24'h0) begin failures++; $display("FAIL mid_data got=%h exp=000000", d_data); end
        checks++; if (d_led !== 4'h0) begin failures++; $display("FAIL mid_led got=%h exp=0", d_led); end
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        e = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            ex = q_d.pop_front(); ac = act_d();
            checks++; if (ac !== ex) begin failures++; $display("FAIL mid_restart e=%0d got=%h exp=%h", e, ac, ex); end
            ex = q_s.pop_front(); ac = act_s();
            checks++; if (ac !== ex) begin failures++; $display("FAIL mid_restart_small e=%0d got=%h exp=%h", e, ac, ex); end
            if (e == 1) begin
                checks++; if (d_de !== 1'b1) begin failures++; $display("FAIL mid_first_de got=%b exp=1", d_de); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_line_timing();
        test_pixels();
        test_frame_timing();
        test_leds();
        test_reset_midline();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
